// File: rtl/mem_arb_pkg.sv
// Shared types and the grant-priority helper for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INS  = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_INS  = 2'd1,
    GRANT_DATA = 2'd2
  } grant_t;

  // Data wins unless the starvation guard asks to let a waiting fetch through.
  function automatic grant_t pick_grant(input logic ins_req, input logic data_req,
                                        input logic force_ins);
    if (data_req && !(force_ins && ins_req)) return GRANT_DATA;
    if (ins_req) return GRANT_INS;
    return GRANT_NONE;
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Wait-cycle counter for an outstanding memory access; expired flags the
// TIMEOUT-th consecutive wait cycle. TIMEOUT=0 never expires.
module mem_arb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW     = $clog2(TIMEOUT + 2);
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  // count is 0 in the first wait cycle, so LAST marks wait cycle number TIMEOUT
  assign expired = (TIMEOUT != 0) && en && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter for a single variable-latency memory port.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ins_req,
  input  logic [ADDR_W-1:0] ins_addr,
  output logic [DATA_W-1:0] ins_rdata,
  output logic              ins_busy,
  input  logic              data_req,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_busy,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_error
);

  arb_state_t        state, state_next;
  grant_t            grant;
  logic              mem_req_next, mem_write_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;
  logic              active, expired, complete, abort, take, force_ins;
  logic              ins_end, data_end;

  assign active   = (state != ARB_IDLE);
  assign complete = active & mem_ready;
  assign abort    = active & ~mem_ready & expired;
  // A new grant can be issued from idle or on the very edge an access completes.
  assign take     = ~active | complete;

  mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (~active | mem_ready | expired),
    .en      (active),
    .expired (expired)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  logic [SW-1:0] starve_cnt, starve_cnt_next;

  assign force_ins = (starve_cnt >= SW'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (grant == GRANT_INS) begin
      starve_cnt_next = '0;
    end else if (grant == GRANT_DATA) begin
      starve_cnt_next = ins_req ? starve_cnt + SW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else        starve_cnt <= starve_cnt_next;
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign force_ins = 1'b0;
`endif

  always_comb begin
    state_next     = state;
    mem_req_next   = mem_req;
    mem_write_next = mem_write;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    grant          = GRANT_NONE;
    if (abort) begin
      state_next     = ARB_IDLE;
      mem_req_next   = 1'b0;
      mem_write_next = 1'b0;
    end else if (take) begin
      grant = pick_grant(ins_req, data_req, force_ins);
      unique case (grant)
        GRANT_DATA: begin
          state_next     = ARB_DATA;
          mem_req_next   = 1'b1;
          mem_write_next = data_write;
          mem_addr_next  = data_addr;
          mem_wdata_next = data_wdata;
        end
        GRANT_INS: begin
          state_next     = ARB_INS;
          mem_req_next   = 1'b1;
          mem_write_next = 1'b0;
          mem_addr_next  = ins_addr;
        end
        default: begin
          state_next     = ARB_IDLE;
          mem_req_next   = 1'b0;
          mem_write_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_next;
      mem_req   <= mem_req_next;
      mem_write <= mem_write_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
    end
  end

  // An aborted access also releases its requester, but with zero read data.
  assign ins_end    = (state == ARB_INS)  & (mem_ready | expired);
  assign data_end   = (state == ARB_DATA) & (mem_ready | expired);
  assign ins_busy   = ins_req  & ~ins_end;
  assign data_busy  = data_req & ~data_end;
  assign ins_rdata  = (ins_req  && state == ARB_INS  && mem_ready) ? mem_rdata : '0;
  assign data_rdata = (data_req && state == ARB_DATA && mem_ready) ? mem_rdata : '0;
  assign bus_error  = abort;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random-traffic scoreboard bench for mem_port_arbiter with a transaction-level
// arbitration model; also covers reset mid-access and the fetch starvation pattern.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 8;
  localparam int SLIM = 4;
  localparam int OWN_NONE = 0;
  localparam int OWN_INS  = 1;
  localparam int OWN_DATA = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ins_req = 1'b0;
  logic [AW-1:0] ins_addr = '0;
  logic [DW-1:0] ins_rdata;
  logic          ins_busy;
  logic          data_req = 1'b0;
  logic          data_write = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic [DW-1:0] data_rdata;
  logic          data_busy;
  logic          mem_req;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          bus_error;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .STARVE_LIMIT(SLIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ins_req(ins_req), .ins_addr(ins_addr), .ins_rdata(ins_rdata), .ins_busy(ins_busy),
    .data_req(data_req), .data_write(data_write), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_busy(data_busy),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_error(bus_error)
  );

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    bit          err;
  } txn_t;

  txn_t ins_q[$];
  txn_t data_q[$];
  byte  seq[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 0;
  int   p_ins = 0, p_data = 0, p_dead = 0, lat_max = 0;
  int   m_owner = OWN_NONE, m_k = 0, m_starve = 0;
  int   age = 0, lat = 0;
  bit   new_acc = 1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h2408_0001;
  endfunction

  function automatic bit is_dead(input logic [31:0] a);
    return a[31:28] == 4'hF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] new_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 99) < p_dead) a[31:28] = 4'hF;
    else if (a[31:28] == 4'hF) a[31:28] = 4'h0;
    return a;
  endfunction

  // Memory: random latency 0..lat_max, dead region never answers, stray strobes when idle.
  task automatic mem_drive();
    if (!mem_req) begin
      new_acc   = 1;
      mem_ready = ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end else begin
      if (new_acc) begin
        age = 0;
        lat = $urandom_range(0, lat_max);
        new_acc = 0;
      end else begin
        age++;
      end
      mem_ready = !is_dead(mem_addr) && (age == lat);
      mem_rdata = mem_ready ? mem_fn(mem_addr) : $urandom;
      if (mem_ready) new_acc = 1;
    end
  endtask

  // Requesters present their next request in the cycle the previous one finishes.
  task automatic drive_reqs();
    if (!ins_req || !ins_busy) begin
      if ($urandom_range(0, 99) < p_ins) begin
        txn_t t;
        t.addr = new_addr();
        t.addr[1:0] = 2'b00;
        t.write = 1'b0;
        t.wdata = '0;
        t.err = is_dead(t.addr);
        ins_req = 1'b1;
        ins_addr = t.addr;
        ins_q.push_back(t);
      end else begin
        ins_req = 1'b0;
      end
    end
    if (!data_req || !data_busy) begin
      if ($urandom_range(0, 99) < p_data) begin
        txn_t t;
        t.addr = new_addr();
        t.write = $urandom_range(0, 1);
        t.wdata = $urandom;
        t.err = is_dead(t.addr);
        data_req = 1'b1;
        data_addr = t.addr;
        data_write = t.write;
        data_wdata = t.wdata;
        data_q.push_back(t);
      end else begin
        data_req = 1'b0;
      end
    end
  endtask

  function automatic bit model_tmo();
    return (m_owner != OWN_NONE) && !mem_ready && (m_k == TMO);
  endfunction

  // Who owns the port after the coming edge, from the arbitration rules.
  task automatic model_step();
    bit force_i;
    force_i = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    force_i = ins_req && (m_starve >= SLIM);
`endif
    if (model_tmo()) begin
      m_owner = OWN_NONE;
      m_k = 0;
    end else if (m_owner == OWN_NONE || mem_ready) begin
      if (data_req && !force_i) begin
        m_owner = OWN_DATA;
        m_starve = ins_req ? m_starve + 1 : 0;
      end else if (ins_req) begin
        m_owner = OWN_INS;
        m_starve = 0;
      end else begin
        m_owner = OWN_NONE;
      end
      m_k = (m_owner != OWN_NONE) ? 1 : 0;
    end else begin
      m_k++;
    end
  endtask

  task automatic do_cycle();
    @(negedge clk);
    mem_drive();
    #2;
    drive_reqs();
    model_step();
  endtask

  task automatic mon_side(input string pfx, input int who, input logic req,
                          input logic busy, input logic [31:0] rdata, input bit tmo);
    logic eb;
    eb = req && !(m_owner == who && (mem_ready || tmo));
    check({pfx, "_busy"}, busy, eb);
    if (req && !busy) begin
      txn_t t;
      if ((who == OWN_INS && ins_q.size() == 0) || (who == OWN_DATA && data_q.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_unexpected_completion: actual=completion required=none at %0t", pfx, $time);
      end else begin
        if (who == OWN_INS) t = ins_q.pop_front();
        else t = data_q.pop_front();
        seq.push_back((who == OWN_INS) ? 8'h49 : 8'h44);
        check({pfx, "_bus_error"}, bus_error, t.err);
        check({pfx, "_mem_addr"}, mem_addr, t.addr);
        check({pfx, "_mem_write"}, mem_write, t.write);
        if (t.write && !t.err) check({pfx, "_mem_wdata"}, mem_wdata, t.wdata);
        if (t.err) check({pfx, "_rdata_abort"}, rdata, 32'h0);
        else if (!t.write) check({pfx, "_rdata"}, rdata, mem_fn(t.addr));
      end
    end else begin
      check({pfx, "_rdata_quiet"}, rdata, 32'h0);
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      bit tmo;
      tmo = model_tmo();
      check("bus_error", bus_error, tmo);
      check("mem_req", mem_req, m_owner != OWN_NONE);
      mon_side("ins", OWN_INS, ins_req, ins_busy, ins_rdata, tmo);
      mon_side("data", OWN_DATA, data_req, data_busy, data_rdata, tmo);
    end
  end

  task automatic drain();
    int n;
    p_ins = 0;
    p_data = 0;
    n = 0;
    while ((ins_q.size() != 0 || data_q.size() != 0 || mem_req) && n < 300) begin
      do_cycle();
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", ins_q.size() + data_q.size());
    end
  endtask

  initial begin
    string exp_seq;
    int n;
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_bus_error", bus_error, 0);
    check("rst_ins_busy", ins_busy, 0);
    check("rst_data_busy", data_busy, 0);
    check("rst_ins_rdata", ins_rdata, 0);
    check("rst_data_rdata", data_rdata, 0);
    #1 rst_n = 1'b1;
    chk_en = 1;

    p_ins = 60; p_data = 60; p_dead = 8; lat_max = 3;
    repeat (3000) do_cycle();
    drain();

    // Park a data access on a dead address, then reset it mid-flight.
    p_data = 100; p_dead = 100;
    n = 0;
    while (!mem_req && n < 20) begin
      do_cycle();
      n++;
    end
    p_data = 0;
    do_cycle();
    #1;
    check("pre_reset_mem_req", mem_req, 1);
    chk_en = 0;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", mem_req, 0);
    check("async_rst_mem_write", mem_write, 0);
    check("async_rst_bus_error", bus_error, 0);
    ins_req = 1'b0;
    data_req = 1'b0;
    ins_q.delete();
    data_q.delete();
    m_owner = OWN_NONE; m_k = 0; m_starve = 0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_ins_busy", ins_busy, 0);
    check("post_rst_data_busy", data_busy, 0);
    #1 chk_en = 1;

    // Both requesters continuously busy with an always-ready memory.
    p_ins = 100; p_data = 100; p_dead = 0; lat_max = 0;
    seq.delete();
    n = 0;
    while (seq.size() < 10 && n < 200) begin
      do_cycle();
      n++;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_seq = "DDDDIDDDDI";
`else
    exp_seq = "DDDDDDDDDD";
`endif
    for (int i = 0; i < 10; i++) begin
      if (i < seq.size()) check("grant_seq", seq[i], exp_seq[i]);
      else check("grant_seq_missing", 0, exp_seq[i]);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
